// File: rtl/setuphold_stim_if.sv
// Handshake and stimulus bundle for setuphold_stim_gen.
// The master side issues a configuration with start; the slave side drives the
// generated clock/data/condition triple and the status strobes.
interface setuphold_stim_if #(
   parameter int CNT_W = 8,
   parameter int NUM_W = 16
);
   logic             start;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] setup_off;
   logic [CNT_W-1:0] hold_off;
   logic [NUM_W-1:0] num_edges;
   logic             cond_en;
   logic             clk_o;
   logic             data_o;
   logic             cond_o;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, period, setup_off, hold_off, num_edges, cond_en,
      input  clk_o, data_o, cond_o, busy, done, err
   );

   modport slave (
      input  start, period, setup_off, hold_off, num_edges, cond_en,
      output clk_o, data_o, cond_o, busy, done, err
   );
endinterface

// File: rtl/setuphold_stim_gen.sv
// Setup/hold stimulus generator.
// One base-clock cycle is one tick. After an accepted start the block spends one
// period in PRE (clock low, leading data toggle setup_off ticks before the first
// rise), then one RUN period per rising edge: clock high for period>>1 ticks,
// trailing data toggle hold_off ticks after the rise, and the next leading toggle
// setup_off ticks before the following rise (skipped in the final period).
// Every output is registered and computed from the next state/tick, so the value
// seen in a cycle always corresponds to the tick held in that cycle.
module setuphold_stim_gen #(
   parameter int CNT_W = 8,
   parameter int NUM_W = 16
) (
   input logic             clk,
   input logic             rst,
   setuphold_stim_if.slave stim
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] tick_q, tick_d;
   logic [NUM_W-1:0] edges_q, edges_d;

   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] setup_q, setup_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic             cfg_cond_q, cfg_cond_d;

   logic             clk_q, clk_d;
   logic             data_q, data_d;
   logic             cond_q, cond_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             accept;
   logic             cfg_ok;
   logic [CNT_W:0]   off_sum;
   logic [CNT_W-1:0] lead_tick;
   logic [CNT_W-1:0] high_ticks;

   // Start acceptance and configuration validity; the offset sum is one bit wider so it cannot wrap.
   always_comb begin
      accept  = (state_q == IDLE) && stim.start;
      off_sum = {1'b0, stim.setup_off} + {1'b0, stim.hold_off};
      cfg_ok  = (stim.period >= CNT_W'(4)) &&
                (stim.setup_off != '0) &&
                (stim.hold_off != '0) &&
                (off_sum < {1'b0, stim.period});
   end

   // Configuration capture: new values only on an accepted start, held for the whole sequence.
   always_comb begin
      period_d   = period_q;
      setup_d    = setup_q;
      hold_d     = hold_q;
      cfg_cond_d = cfg_cond_q;
      if (accept) begin
         period_d   = stim.period;
         setup_d    = stim.setup_off;
         hold_d     = stim.hold_off;
         cfg_cond_d = stim.cond_en;
      end
   end

   // Sequencer next state plus output values derived from the next state and tick.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      edges_d = edges_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (!cfg_ok) begin
                  err_d = 1'b1;
               end else if (stim.num_edges == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = PRE;
                  tick_d  = '0;
                  edges_d = stim.num_edges;
               end
            end
         end
         PRE: begin
            if (tick_q == period_q - CNT_W'(1)) begin
               state_d = RUN;
               tick_d  = '0;
            end else begin
               tick_d = tick_q + CNT_W'(1);
            end
         end
         RUN: begin
            if (tick_q == period_q - CNT_W'(1)) begin
               tick_d  = '0;
               edges_d = edges_q - NUM_W'(1);
               if (edges_q == NUM_W'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               tick_d = tick_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            tick_d  = '0;
         end
      endcase

      // Leading toggle tick and clock-high length for the period being entered.
      lead_tick  = period_d - setup_d;
      high_ticks = period_d >> 1;

      data_d = data_q;
      clk_d  = 1'b0;
      case (state_d)
         PRE: begin
            if (tick_d == lead_tick) data_d = ~data_q;
         end
         RUN: begin
            clk_d = (tick_d < high_ticks);
            if (tick_d == hold_d) data_d = ~data_q;
            // edges_d already counts the current period, so 1 marks the final one.
            if ((tick_d == lead_tick) && (edges_d != NUM_W'(1))) data_d = ~data_q;
         end
         default: ;
      endcase

      busy_d = (state_d != IDLE);
      cond_d = busy_d & cfg_cond_d;
   end

   // Control, counters and registered outputs; reset returns everything to idle and zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         tick_q  <= '0;
         edges_q <= '0;
         clk_q   <= 1'b0;
         data_q  <= 1'b0;
         cond_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         edges_q <= edges_d;
         clk_q   <= clk_d;
         data_q  <= data_d;
         cond_q  <= cond_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Latched configuration is plain data and needs no reset.
   always_ff @(posedge clk) begin
      period_q   <= period_d;
      setup_q    <= setup_d;
      hold_q     <= hold_d;
      cfg_cond_q <= cfg_cond_d;
   end

   assign stim.clk_o  = clk_q;
   assign stim.data_o = data_q;
   assign stim.cond_o = cond_q;
   assign stim.busy   = busy_q;
   assign stim.done   = done_q;
   assign stim.err    = err_q;

endmodule

// File: tb/tb_setuphold_stim_gen.sv
// Testbench for setuphold_stim_gen: directed scenarios followed by randomized
// configurations, each compared cycle by cycle against waveform expectations
// computed from the sequence timing formulas (rise k at cycle 1 + k*period,
// toggles setup_off before and hold_off after each rise, done after the last period).
module tb_setuphold_stim_gen;
   localparam int CNT_W = 8;
   localparam int NUM_W = 16;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_fail = 0;
   bit   mdl_data;

   setuphold_stim_if #(.CNT_W(CNT_W), .NUM_W(NUM_W)) stim ();

   setuphold_stim_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
      .clk  (clk),
      .rst  (rst),
      .stim (stim)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int k, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s k=%0d observed=%0b expected=%0b", tag, k, obs, exp);
      end
   endtask

   task automatic check_outputs(input int k, input bit e_clk, input bit e_data, input bit e_cond,
                                input bit e_busy, input bit e_done, input bit e_err);
      check("clk_o",  k, stim.clk_o,  e_clk);
      check("data_o", k, stim.data_o, e_data);
      check("cond_o", k, stim.cond_o, e_cond);
      check("busy",   k, stim.busy,   e_busy);
      check("done",   k, stim.done,   e_done);
      check("err",    k, stim.err,    e_err);
   endtask

   // True when cycle k (relative to the start cycle) carries a data toggle.
   function automatic bit toggles_at(input int k, input int p, input int su, input int ho, input int n);
      for (int j = 1; j <= n; j++) begin
         if (k == 1 + j * p - su) return 1'b1;
         if (k == 1 + j * p + ho) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_outputs(-1, 1'b0, mdl_data, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   // Called at a negedge: drives start for cycle 0, then checks cycles 1..end.
   // disturb_at > 0: pulse start with new period/setup at that cycle (must be ignored).
   // rst_at > 0: assert rst at that cycle and expect all-zero outputs one cycle later.
   task automatic run_seq(input int p, input int su, input int ho, input int n, input bit c,
                          input int disturb_at, input int rst_at);
      bit valid;
      int k_end;
      bit e_busy, e_clk, e_done, e_err;
      valid = (p >= 4) && (su >= 1) && (ho >= 1) && (su + ho < p);
      k_end = (valid && n > 0) ? (n + 1) * p + 1 : 1;
      stim.start     = 1'b1;
      stim.period    = 8'(p);
      stim.setup_off = 8'(su);
      stim.hold_off  = 8'(ho);
      stim.num_edges = 16'(n);
      stim.cond_en   = c;
      for (int k = 1; k <= k_end; k++) begin
         @(negedge clk);
         if (k == 1) stim.start = 1'b0;
         if (rst_at > 0 && k == rst_at + 1) begin
            check_outputs(k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            rst = 1'b0;
            mdl_data = 1'b0;
            return;
         end
         e_busy = valid && (n > 0) && (k <= (n + 1) * p);
         e_clk  = e_busy && (k >= 1 + p) && (((k - 1) % p) < p / 2);
         if (valid && n > 0 && toggles_at(k, p, su, ho, n)) mdl_data = ~mdl_data;
         e_done = valid && ((n == 0 && k == 1) || (n > 0 && k == (n + 1) * p + 1));
         e_err  = !valid && (k == 1);
         check_outputs(k, e_clk, mdl_data, e_busy & c, e_busy, e_done, e_err);
         if (k == rst_at) rst = 1'b1;
         if (disturb_at > 0 && k == disturb_at) begin
            stim.start     = 1'b1;
            stim.period    = 8'($urandom_range(4, 30));
            stim.setup_off = 8'($urandom_range(1, 3));
         end
         if (disturb_at > 0 && k == disturb_at + 1) stim.start = 1'b0;
      end
   endtask

   initial begin
      int p, su, ho, n;
      bit c;
      rst            = 1'b1;
      stim.start     = 1'b0;
      stim.period    = '0;
      stim.setup_off = '0;
      stim.hold_off  = '0;
      stim.num_edges = '0;
      stim.cond_en   = 1'b0;
      mdl_data       = 1'b0;
      repeat (3) @(negedge clk);
      check_outputs(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      idle(2);

      // Basic sequence
      run_seq(8, 2, 3, 2, 1'b0, 0, 0);
      idle(2);

      // Invalid configurations, including one whose 8-bit offset sum would wrap
      run_seq(3, 1, 1, 2, 1'b1, 0, 0);
      idle(2);
      run_seq(8, 0, 3, 2, 1'b1, 0, 0);
      idle(2);
      run_seq(8, 4, 4, 2, 1'b1, 0, 0);
      idle(2);
      run_seq(255, 200, 200, 1, 1'b1, 0, 0);
      idle(2);

      // Zero edges
      run_seq(8, 2, 3, 0, 1'b1, 0, 0);
      idle(3);

      // Start and config changes during RUN, then back-to-back start in the done cycle
      run_seq(8, 2, 3, 3, 1'b1, 12, 0);
      run_seq(6, 1, 2, 2, 1'b0, 0, 0);
      idle(2);

      // Reset mid-RUN, then a full sequence
      run_seq(8, 2, 3, 2, 1'b1, 0, 14);
      idle(2);
      run_seq(8, 2, 3, 2, 1'b1, 0, 0);
      idle(2);

      // Odd period with extreme offsets
      run_seq(9, 1, 7, 3, 1'b0, 0, 0);
      idle(2);

      // Randomized configurations, some invalid, with random idle gaps
      for (int i = 0; i < 10; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            p  = $urandom_range(0, 12);
            su = $urandom_range(0, 8);
            ho = $urandom_range(0, 8);
         end else begin
            p  = $urandom_range(4, 16);
            su = $urandom_range(1, p - 2);
            ho = $urandom_range(1, p - 1 - su);
         end
         n = $urandom_range(0, 4);
         c = 1'($urandom_range(0, 1));
         run_seq(p, su, ho, n, c, 0, 0);
         idle($urandom_range(0, 2));
      end
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/setuphold_stim_gen.md
# setuphold_stim_gen

Synthesizable stimulus generator that drives a clock/data/condition triple with data transitions at programmed tick offsets before and after each generated clock rising edge. It is the driving end for `$setuphold` timing-check models with notifier and condition arguments. Benches and on-chip self-test use it to place data edges precisely inside or outside a setup/hold window. It runs on a fast base clock; one base-clock cycle is one tick of the generated clock period.

## Interface
- `CNT_W`, 8: width of `period`, `setup_off`, `hold_off`, and the tick counter.
- `NUM_W`, 16: width of `num_edges` and the edge counter.

Ports:
- `clk` in 1: base clock, rising-edge. One cycle = one tick.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request a sequence. Sampled only when idle.
- `period` in CNT_W: ticks per generated clock period.
- `setup_off` in CNT_W: ticks from the leading data toggle to the rising edge.
- `hold_off` in CNT_W: ticks from the rising edge to the trailing data toggle.
- `num_edges` in NUM_W: number of rising edges to generate.
- `cond_en` in 1: value driven on `cond_o` for the sequence.
- `clk_o` out 1: generated clock.
- `data_o` out 1: generated data.
- `cond_o` out 1: generated condition.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle configuration-error pulse.

## Operation
- States: IDLE, PRE, RUN.
- Config latch: `start` is accepted only in IDLE. On acceptance, `period`, `setup_off`, `hold_off`, `num_edges` and `cond_en` are latched. Later input changes have no effect.
- Validity rules:
  - `period >= 4`, `setup_off >= 1`, `hold_off >= 1`.
  - `setup_off + hold_off < period`, with the sum computed at CNT_W+1 bits (no wrap).
  - An invalid config gives `err` pulse, no `done`, and the block stays in IDLE.
- `num_edges == 0` with a valid config gives a `done` pulse. No `busy`, no output activity.
- Otherwise the block enters PRE with tick = 0.
- Tick counter runs 0..period-1 and wraps. Let S = period - setup_off and H = period >> 1.
- PRE (one period):
  - `clk_o` = 0.
  - `data_o` toggles at tick S.
  - At tick period-1 go to RUN.
- RUN (one period per edge):
  - `clk_o` = 1 for ticks 0..H-1 and 0 otherwise; an odd period gives a shorter high phase.
  - `data_o` toggles at tick `hold_off`.
  - `data_o` toggles at tick S except in the final period.
  - The edge counter decrements at tick period-1.
  - When the final period ends, pulse `done` and return to IDLE.
- Total data toggles per sequence = 2 × `num_edges`, so `data_o` ends at its starting value.
- `cond_o` = latched `cond_en` while `busy`, 0 in IDLE.
- `start` while busy is ignored; no queuing.
- `rst` at any time, including mid-sequence: IDLE immediately, all outputs 0, counters cleared.

## Timing
- All outputs are registered. "At tick t" means the output value in the cycle where tick == t.
- Reset values: `clk_o`, `data_o`, `cond_o`, `busy`, `done`, `err` all 0.
- `start` sampled in cycle 0:
  - `busy` = 1 and `cond_o` valid from cycle 1, with PRE tick 0 in cycle 1.
  - `err`, or `done` for the zero-edge case, asserts in cycle 1.
- First `clk_o` rise is at cycle 1 + period. Rise k is at cycle 1 + k·period.
- The final RUN period ends at cycle (num_edges+1)·period. `done` = 1 and `busy` = 0 in the following cycle.
- A new `start` is accepted in the `done` cycle.
- `data_o` leading toggle is exactly `setup_off` cycles before each rise. Trailing toggle is exactly `hold_off` cycles after it.

## Test plan
- Basic sequence: period=8, setup=2, hold=3, num=2, start at cycle 0.
  - Expect `clk_o` rises at 9 and 17, falls at 13 and 21.
  - Expect `data_o` toggles at 7, 12, 15, 20.
  - Expect `done` at 25 with `busy` low at 25; `data_o` final value = initial value.
- Invalid configs, each started separately: period=3; setup=0; setup=4 with hold=4 and period=8.
  - Expect an `err` pulse at cycle 1 for each.
  - Expect no `busy`, no `done`, outputs unchanged.
- Zero edges: num=0 with a valid config.
  - Expect `done` at cycle 1, `busy` never high, `clk_o` and `data_o` flat.
- Start while busy, plus input changes mid-sequence:
  - A second `start` and new `period`/`setup_off` values during RUN are ignored; timing matches the first config.
  - Back-to-back `start` in the `done` cycle is accepted.
- Reset mid-RUN with `cond_en`=1: assert `rst` at cycle 14.
  - Expect all outputs 0 at cycle 15.
  - A subsequent `start` produces the full sequence from PRE.
- Odd period and extremes: period=9, setup=1, hold=7, num=3.
  - Expect a high phase of 4 ticks.
  - Expect toggles exactly 1 cycle before and 7 cycles after each rise.
